// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, opcode constants and fetch FSM encoding for the fetch/decode slice.
// Imported by the fetch unit, its next-pc selector, the bus interface and benches.
package instr_fetch_unit_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: ROM address/data, redirect/stall controls from execute, IF/ID outputs.
// master = fetch unit, slave = ROM plus pipeline environment.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_base;
    logic [15:0]        branch_offset;
    logic               jump;
    logic [25:0]        jump_target;
    logic               fetch_valid;
    logic [INSTR_W-1:0] fetch_instr;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    fetch_pc_plus1;
    logic               halted;

    modport master (
        output imem_addr, fetch_valid, fetch_instr, fetch_pc, fetch_pc_plus1, halted,
        input  imem_data, stall, branch_taken, branch_base, branch_offset, jump, jump_target
    );

    modport slave (
        input  imem_addr, fetch_valid, fetch_instr, fetch_pc, fetch_pc_plus1, halted,
        output imem_data, stall, branch_taken, branch_base, branch_offset, jump, jump_target
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Combinational next-pc priority mux (jump > branch > stall > pc+1) with mod-256 branch adder.
// Zero latency; o_redirect flags a jump or taken branch so the caller can flush IF/ID.
module next_pc_sel
    import instr_fetch_unit_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_stall,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_target,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_base,
    input  logic [PC_W-1:0] i_branch_offset,
    output logic [PC_W-1:0] o_next_pc,
    output logic            o_redirect
);

    logic [PC_W-1:0] w_branch_target;

    // Only the low offset byte matters: the sum wraps at the 8-bit pc width anyway.
    assign w_branch_target = i_branch_base + i_branch_offset;
    assign o_redirect      = i_jump | i_branch_taken;

    always_comb begin
        o_next_pc = i_pc + 8'd1;
        if (i_jump)
            o_next_pc = i_jump_target;
        else if (i_branch_taken)
            o_next_pc = w_branch_target;
        else if (i_stall)
            o_next_pc = i_pc;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: pc register, IF/ID register (one-edge ROM-to-decode latency), zero-run halt.
// Stall holds pc and IF/ID; a redirect overrides stall and inserts exactly one bubble.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'd0,
    parameter int unsigned     ZERO_RUN = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    instr_fetch_unit_if.master    bus
);

    localparam logic [0:0] ST_RUN    = 1'(RUN);
    localparam logic [0:0] ST_HALTED = 1'(HALTED);
    localparam logic [7:0] ZR        = 8'(ZERO_RUN);

    logic [0:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_fetch_pc;
    logic [PC_W-1:0]    r_fetch_pc_plus1;
    logic [7:0]         r_zero_cnt;

    logic [PC_W-1:0]    w_next_pc;
    logic               w_redirect;
    logic               w_zero_word;
    logic               w_run_done;
    logic               w_unused;

    assign w_unused = &{1'b0, bus.jump_target[25:PC_W], bus.branch_offset[15:PC_W]};

    next_pc_sel u_next_pc_sel (
        .i_pc            (r_pc),
        .i_stall         (bus.stall),
        .i_jump          (bus.jump),
        .i_jump_target   (bus.jump_target[PC_W-1:0]),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_base   (bus.branch_base),
        .i_branch_offset (bus.branch_offset[PC_W-1:0]),
        .o_next_pc       (w_next_pc),
        .o_redirect      (w_redirect)
    );

    assign w_zero_word = (bus.imem_data == '0);
    // The word completing the run is swallowed: it halts fetch instead of loading IF/ID.
    assign w_run_done  = (ZR != 8'd0) && w_zero_word && ((r_zero_cnt + 8'd1) == ZR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_RUN;
            r_pc             <= RESET_PC;
            r_valid          <= 1'b0;
            r_instr          <= '0;
            r_fetch_pc       <= '0;
            r_fetch_pc_plus1 <= '0;
            r_zero_cnt       <= 8'd0;
        end else if (r_state == ST_RUN) begin
            if (w_redirect) begin
                r_pc    <= w_next_pc;
                r_valid <= 1'b0;
                r_instr <= '0;
            end else if (!bus.stall) begin
                if (w_run_done) begin
                    r_state    <= ST_HALTED;
                    r_valid    <= 1'b0;
                    r_instr    <= '0;
                    r_zero_cnt <= ZR;
                end else begin
                    r_pc             <= w_next_pc;
                    r_valid          <= 1'b1;
                    r_instr          <= bus.imem_data;
                    r_fetch_pc       <= r_pc;
                    r_fetch_pc_plus1 <= r_pc + 8'd1;
                    if (!w_zero_word)
                        r_zero_cnt <= 8'd0;
                    else if (r_zero_cnt < ZR)
                        r_zero_cnt <= r_zero_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.imem_addr      = r_pc;
    assign bus.fetch_valid    = r_valid;
    assign bus.fetch_instr    = r_instr;
    assign bus.fetch_pc       = r_fetch_pc;
    assign bus.fetch_pc_plus1 = r_fetch_pc_plus1;
    assign bus.halted         = (r_state == ST_HALTED);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the word-addressed instruction ROM. Owns the program counter, drives the 8-bit ROM address, and captures the returned 32-bit word into an IF/ID pipeline register for decode.
- Supports stall, branch/jump redirect with a one-bubble flush, and a halt detector that stops fetch once the program has run into zero-filled memory.

Parameters:
- RESET_PC, 8'd0, word address fetched first after reset.
- ZERO_RUN, 4, consecutive valid all-zero words that trigger halt; 0 disables halt.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  8  word address to the instruction ROM; always equals the pc register.
- imem_data  in  32  combinational ROM read data for imem_addr.
- stall  in  1  hold pc and the IF/ID register.
- branch_taken  in  1  conditional-branch redirect request from execute.
- branch_base  in  8  pc+1 of the branch instruction.
- branch_offset  in  16  signed word offset (instruction[15:0]).
- jump  in  1  absolute-jump redirect request.
- jump_target  in  26  instruction[25:0]; only bits [7:0] are used.
- fetch_valid  out  1  IF/ID holds a real instruction.
- fetch_instr  out  32  IF/ID instruction word.
- fetch_pc  out  8  address of fetch_instr.
- fetch_pc_plus1  out  8  fetch_pc+1 mod 256.
- halted  out  1  fetch stopped by the zero-run detector.

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - pc=RESET_PC; fetch_valid=0, fetch_instr=0, fetch_pc=0, fetch_pc_plus1=0; halted=0; zero counter=0; state=RUN.
- Latency: the ROM word at pc appears on fetch_instr one clock edge later. The first valid fetch is visible after the first edge following reset release.
- Next-pc priority in RUN, highest first:
  - jump: pc <= jump_target[7:0].
  - branch_taken: pc <= branch_base + branch_offset[7:0], mod 256; upper offset bits are ignored.
  - stall: pc holds.
  - otherwise: pc <= pc+1; 255 wraps to 0.
- IF/ID update in RUN:
  - Redirect (jump or branch_taken): load a bubble (valid=0, instr=0, pc fields unchanged). A redirect overrides a stall in the same cycle.
  - stall without redirect: hold all IF/ID fields.
  - Otherwise: valid=1, instr=imem_data, fetch_pc=pc, fetch_pc_plus1=pc+1.
- Jump and branch_taken asserted together: jump wins, a single bubble is inserted.
- Zero-run detector, evaluated only on cycles that load a valid word:
  - imem_data==0 increments the counter, saturating at ZERO_RUN; a nonzero word clears it.
  - When the increment reaches ZERO_RUN (ZERO_RUN!=0), go to HALTED on the same edge.
  - Stalled or redirected cycles leave the counter unchanged.
- HALTED:
  - pc frozen; fetch_valid=0 and instr=0 from the transition edge onward; halted=1.
  - stall, jump and branch inputs are ignored. Only reset exits.
  - The zero word that completes the run is never presented as valid.
- Reset mid-stall or mid-redirect: the asynchronous clear wins immediately and no redirect target is retained.
- State machine: RUN -> HALTED (zero-run complete); HALTED -> RUN only via reset_n low.

Decomposition:
- Shared package holds:
  - PC_W=8, INSTR_W=32.
  - Opcode constants OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_J=6'b000010, for decode/bench reuse.
  - The fetch_state enum {RUN, HALTED}.
- One natural sub-module: next_pc_sel, a combinational priority mux plus branch adder. The pc/IF-ID registers and the halt FSM stay in the top module.

Test Plan:
- Reset release, ROM loaded with the 14-word arithmetic/branch program, no stalls -> fetch_pc reads 0,1,2,3 on successive cycles; fetch_instr at pc 0 = 32'h02328020; fetch_valid=1 from the first edge.
- Word 4 (beq, offset 1) in decode; drive branch_taken=1, branch_base=5, branch_offset=1 -> next pc=6; one cycle with fetch_valid=0; next valid fetch_pc=6 with instr 32'h22130003.
- Stall held 3 cycles while fetch_pc=2 -> imem_addr stays 3 and fetch_instr stays 32'h02108024 throughout; on release fetch_pc advances to 3.
- jump=1 with jump_target=26'd9 together with branch_taken=1, branch_base=5, branch_offset=1, and stall=1 -> pc=9 (jump wins); exactly one bubble; then fetch_pc=9 with fetch_valid=1.
- Run past the last program word (word 13) with ZERO_RUN=4 -> words 14,15,16 presented valid with instr=0; on word 17, halted=1 and fetch_valid=0; pc holds 17 despite jump pulses.
- RESET_PC=8'd255, stall low -> fetch_pc 255 then 0 (wrap); assert reset_n=0 asynchronously mid-cycle during an active redirect -> all outputs clear immediately, pc=255 after release.
